fifo_word_reader: RTL and testbench

- Read-side consumer for the team's 8-bit FIFO.
- Pops bytes using the FIFO's `rd`/`empty`/`op` interface and packs them little-endian into 32-bit words.
- Presents each packed word on a valid/ready output handshake.
- Supports a flush request that emits a partial word when the FIFO runs dry, and counts delivered words.

---
 rtl/fifo_word_reader.sv | 113 +++++++++++
 tb/tb_fifo_word_reader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_reader.sv
// Read-side consumer for the 8-bit FIFO: pops bytes, packs them little-endian
// into BPW-byte words, and presents each word on a valid/ready handshake.
module fifo_word_reader #(
  parameter int DATA_W = 8,
  parameter int BPW    = 4,
  parameter int CNT_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     fifo_op,
  input  logic                  fifo_empty,
  input  logic [CNT_W-1:0]      fifo_cnt,
  output logic                  fifo_rd,
  input  logic                  flush,
  output logic [DATA_W*BPW-1:0] word_out,
  output logic [2:0]            word_bytes,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic [15:0]           word_cnt
);

  localparam int CW = $clog2(BPW + 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t          state_reg;
  logic [CW-1:0]   issued_reg;
  logic [CW-1:0]   captured_reg;
  logic            pending_reg;
  logic [CW-1:0]   captured_next;
  logic            full_next;
  logic            flush_go;
  logic            handshake;
  logic [BPW-1:0]  lane_we;
  logic            unused_fifo_cnt;

  assign unused_fifo_cnt = ^fifo_cnt;

  assign fifo_rd = rst && (state_reg == FILL) && !fifo_empty
                   && (issued_reg < CW'(BPW));

  assign captured_next = captured_reg + CW'(1);
  assign full_next     = pending_reg && (captured_next == CW'(BPW));
  assign handshake     = word_valid && word_ready;

  // A partial word may only leave once every issued byte has landed.
  assign flush_go = (state_reg == FILL) && flush && fifo_empty && !pending_reg
                    && (issued_reg == captured_reg) && (captured_reg != '0);

  // Each byte lane is its own register, cleared whenever a word is handed off.
  for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
    logic [DATA_W-1:0] lane_reg;

    assign lane_we[gi] = pending_reg && (captured_reg == CW'(gi));
    assign word_out[gi*DATA_W +: DATA_W] = lane_reg;

    always_ff @(posedge clk) begin
      if (!rst) begin
        lane_reg <= '0;
      end else if (handshake) begin
        lane_reg <= '0;
      end else if (lane_we[gi]) begin
        lane_reg <= fifo_op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= FILL;
      issued_reg   <= '0;
      captured_reg <= '0;
      pending_reg  <= 1'b0;
      word_bytes   <= '0;
      word_valid   <= 1'b0;
      word_cnt     <= '0;
    end else begin
      pending_reg <= fifo_rd;
      if (fifo_rd) begin
        issued_reg <= issued_reg + CW'(1);
      end
      if (pending_reg) begin
        captured_reg <= captured_next;
      end

      case (state_reg)
        FILL: begin
          if (full_next) begin
            state_reg  <= HOLD;
            word_valid <= 1'b1;
            word_bytes <= 3'(BPW);
          end else if (flush_go) begin
            state_reg  <= HOLD;
            word_valid <= 1'b1;
            word_bytes <= 3'(captured_reg);
          end
        end
        HOLD: begin
          if (word_ready) begin
            state_reg    <= FILL;
            word_valid   <= 1'b0;
            word_bytes   <= '0;
            word_cnt     <= word_cnt + 16'd1;
            issued_reg   <= '0;
            captured_reg <= '0;
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_reader.sv
// Directed bench for fifo_word_reader with a behavioural FIFO model that
// honours the one-cycle read latency contract.
module tb_fifo_word_reader;

  localparam int DATA_W = 8;
  localparam int BPW    = 4;
  localparam int CNT_W  = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [DATA_W-1:0]     fifo_op;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  fifo_rd;
  logic                  flush;
  logic [DATA_W*BPW-1:0] word_out;
  logic [2:0]            word_bytes;
  logic                  word_valid;
  logic                  word_ready;
  logic [15:0]           word_cnt;

  int checks   = 0;
  int failures = 0;

  fifo_word_reader #(.DATA_W(DATA_W), .BPW(BPW), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_op    (fifo_op),
    .fifo_empty (fifo_empty),
    .fifo_cnt   (fifo_cnt),
    .fifo_rd    (fifo_rd),
    .flush      (flush),
    .word_out   (word_out),
    .word_bytes (word_bytes),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: pushes from the stimulus block, pops on the clock.
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_cycles = 0;
  int rd_empty  = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_cnt   = CNT_W'(wr_ptr - rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd && !fifo_empty) begin
      fifo_op <= mem[rd_ptr[7:0]];
      rd_ptr  <= rd_ptr + 1;
    end
    if (fifo_rd) rd_cycles <= rd_cycles + 1;
    if (fifo_rd && fifo_empty) rd_empty <= rd_empty + 1;
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Steps negedges until word_valid is seen or the budget expires.
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!word_valid && n < 40);
    check({tag, "_valid"}, 32'(word_valid), 32'd1);
  endtask

  int n;
  int r0;
  int e0;
  logic seen;

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    word_ready = 1'b0;
    fifo_op = '0;

    // 1: reset, then one full word with ready held high
    repeat (2) @(negedge clk);
    check("rst_word_out", word_out, 32'h0);
    check("rst_word_bytes", 32'(word_bytes), 32'd0);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    rst = 1'b1;
    word_ready = 1'b1;
    r0 = rd_cycles;
    push(8'h11); push(8'h06); push(8'h43); push(8'h14);
    wait_valid("t1", n);
    check("t1_latency", 32'(n), 32'd5);
    check("t1_word_out", word_out, 32'h14430611);
    check("t1_word_bytes", 32'(word_bytes), 32'd4);
    @(negedge clk);
    check("t1_valid_drop", 32'(word_valid), 32'd0);
    check("t1_word_cnt", 32'(word_cnt), 32'd1);
    check("t1_rd_cycles", 32'(rd_cycles - r0), 32'd4);
    $display("t1 word=0x14430611 cnt=%0d", word_cnt);

    // 2: backpressure with the next word already waiting in the FIFO
    word_ready = 1'b0;
    push(8'h11); push(8'h06); push(8'h43); push(8'h14);
    push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
    wait_valid("t2a", n);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t2_hold_valid", 32'(word_valid), 32'd1);
      check("t2_hold_word", word_out, 32'h14430611);
      check("t2_hold_rd", 32'(fifo_rd), 32'd0);
    end
    word_ready = 1'b1;
    @(negedge clk);
    check("t2_valid_drop", 32'(word_valid), 32'd0);
    check("t2_cnt_a", 32'(word_cnt), 32'd2);
    wait_valid("t2b", n);
    check("t2_latency", 32'(n), 32'd5);
    check("t2_word_b", word_out, 32'hD4C3B2A1);
    @(negedge clk);
    check("t2_cnt_b", 32'(word_cnt), 32'd3);
    $display("t2 words=0x14430611,0xD4C3B2A1 cnt=%0d", word_cnt);

    // 3: flush of a 2-byte partial word, then flush with nothing captured
    push(8'hAA); push(8'hBB);
    flush = 1'b1;
    wait_valid("t3", n);
    check("t3_word_out", word_out, 32'h0000BBAA);
    check("t3_word_bytes", 32'(word_bytes), 32'd2);
    @(negedge clk);
    check("t3_cnt", 32'(word_cnt), 32'd4);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | word_valid;
    end
    check("t3_no_empty_word", 32'(seen), 32'd0);
    flush = 1'b0;
    $display("t3 word=0x0000BBAA bytes=2 cnt=%0d", word_cnt);

    // 4: two consecutive words
    r0 = rd_cycles;
    e0 = rd_empty;
    for (int b = 1; b <= 8; b++) push(8'(b));
    wait_valid("t4a", n);
    check("t4_word_a", word_out, 32'h04030201);
    wait_valid("t4b", n);
    check("t4_word_b", word_out, 32'h08070605);
    @(negedge clk);
    check("t4_cnt", 32'(word_cnt), 32'd6);
    check("t4_rd_while_empty", 32'(rd_empty - e0), 32'd0);
    check("t4_rd_cycles", 32'(rd_cycles - r0), 32'd8);
    $display("t4 words=0x04030201,0x08070605 cnt=%0d", word_cnt);

    // 5: reset after two captures; the byte in flight is discarded
    push(8'h21); push(8'h22); push(8'h23); push(8'h24);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_word_out", word_out, 32'h0);
    check("t5_word_bytes", 32'(word_bytes), 32'd0);
    check("t5_word_valid", 32'(word_valid), 32'd0);
    check("t5_word_cnt", 32'(word_cnt), 32'd0);
    check("t5_fifo_rd", 32'(fifo_rd), 32'd0);
    rst = 1'b1;
    push(8'h31); push(8'h32); push(8'h33);
    wait_valid("t5", n);
    check("t5_fresh_word", word_out, 32'h33323124);
    check("t5_fresh_bytes", 32'(word_bytes), 32'd4);
    @(negedge clk);
    check("t5_cnt", 32'(word_cnt), 32'd1);
    $display("t5 word=0x33323124 cnt=%0d", word_cnt);

    // 6: counter wrap via backdoor preload
    force dut.word_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.word_cnt;
    @(negedge clk);
    check("t6_preload", 32'(word_cnt), 32'h0000FFFF);
    push(8'h5A);
    flush = 1'b1;
    wait_valid("t6", n);
    check("t6_word_out", word_out, 32'h0000005A);
    check("t6_word_bytes", 32'(word_bytes), 32'd1);
    @(negedge clk);
    check("t6_wrap", 32'(word_cnt), 32'd0);
    flush = 1'b0;
    $display("t6 word=0x0000005A cnt=%0d", word_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
